mips_uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter that sits on the single-cycle CPU's data-memory bus as a responder beside the data memory. The CPU's store/load traffic (address, write enable, byte width, write data) is decoded here into register accesses. Bytes are queued in a small FIFO and serialised on `txd` as 8N1 frames, or 8E1 frames when parity is compiled in. Reads are combinational so a load completes in the CPU's single cycle.

---
 rtl/mips_uart_pkg.sv | 53 +++++
 rtl/mips_sync_fifo.sv | 75 +++++++
 rtl/mips_uart_tx_mmio.sv | 241 ++++++++++++++++++++++++
 tb/tb_mips_uart_tx_mmio.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_uart_pkg.sv
// rtl/mips_uart_pkg.sv - shared constants and types for the MMIO UART transmitter
package mips_uart_pkg;

    // Register select values taken from addr[3:2]
    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;
    localparam logic [1:0] REG_RSVD    = 2'd3;

    // STATUS register bit positions
    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;
    localparam int ST_CNT_W   = 5;
    localparam int ST_PARITY  = 9;

    // byte_width encodings driven by the CPU
    localparam logic [1:0] BW_BYTE    = 2'b00;
    localparam logic [1:0] BW_HALF    = 2'b01;
    localparam logic [1:0] BW_WORD    = 2'b10;
    localparam logic [1:0] BW_ILLEGAL = 2'b11;

`ifdef MIPS_UART_TX_PARITY_EN
    localparam logic PARITY_PRESENT = 1'b1;
`else
    localparam logic PARITY_PRESENT = 1'b0;
`endif

    // Transmit FSM states; TX_PARITY is only reachable with parity compiled in
    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    // True when the access address is not aligned for the given width
    function automatic logic misaligned(input logic [1:0] bw, input logic [1:0] a);
        logic m;
        m = 1'b0;
        case (bw)
            BW_BYTE: m = 1'b0;
            BW_HALF: m = a[0];
            BW_WORD: m = (a != 2'b00);
            default: m = 1'b1;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mips_sync_fifo.sv
// rtl/mips_sync_fifo.sv - first-word-fall-through synchronous FIFO with count
module mips_sync_fifo
    import mips_uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full FIFO still lands when the same cycle frees a slot
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset discards contents
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/mips_uart_tx_mmio.sv
// rtl/mips_uart_tx_mmio.sv - MMIO UART transmitter on the CPU data bus (MIPS_UART_TX_PARITY_EN adds even parity)
module mips_uart_tx_mmio
    import mips_uart_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [1:0]  byte_width,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        err,
    output logic        txd,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        par_q, par_d;
    logic        txd_q, txd_d;
    logic        irq_q;
    logic        ovf_q, ovf_d;
    logic [15:0] div_q, div_d;

    logic [1:0]  sel;
    logic        wr_ok;
    logic        push_req;
    logic        pop;
    logic        bit_end;
    logic        busy;
    logic        fifo_full, fifo_empty;
    logic [7:0]  fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic [ST_CNT_W-1:0] cnt5;
    logic [31:0] status_word;
    logic        unused_bits;

    assign sel         = addr[3:2];
    assign unused_bits = ^{addr[31:4], wdata[31:16]};

    // Access error: illegal width, misalignment, narrow access to word registers, reserved slot
    always_comb begin
        err = 1'b0;
        if (cs) begin
            err = (byte_width == BW_ILLEGAL)
               || misaligned(byte_width, addr[1:0])
               || (sel == REG_RSVD)
               || (((sel == REG_STATUS) || (sel == REG_BAUDDIV)) && (byte_width != BW_WORD));
        end
    end

    assign wr_ok    = cs && we && !err;
    assign push_req = wr_ok && (sel == REG_TXDATA);

    mips_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_req),
        .wdata_i (wdata[7:0]),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign busy    = (state_q != TX_IDLE);
    assign bit_end = (cnt_q == 16'd0);
    assign cnt5    = ST_CNT_W'(fifo_count);

    // STATUS word assembled from live FIFO/FSM state
    always_comb begin
        status_word                        = '0;
        status_word[ST_BUSY]               = busy;
        status_word[ST_FULL]               = fifo_full;
        status_word[ST_EMPTY]              = fifo_empty;
        status_word[ST_OVF]                = ovf_q;
        status_word[ST_CNT_LSB +: ST_CNT_W] = cnt5;
        status_word[ST_PARITY]             = PARITY_PRESENT;
    end

    // Combinational read mux so a load completes in one CPU cycle
    always_comb begin
        rdata = '0;
        if (cs) begin
            case (sel)
                REG_STATUS:  rdata = status_word;
                REG_BAUDDIV: rdata = {16'd0, div_q};
                default:     rdata = '0;
            endcase
        end
    end

    // Register-write side effects: baud divisor and sticky overflow
    always_comb begin
        div_d = div_q;
        ovf_d = ovf_q;
        if (wr_ok && (sel == REG_BAUDDIV)) begin
            div_d = wdata[15:0];
        end
        if (wr_ok && (sel == REG_STATUS) && wdata[ST_OVF]) begin
            ovf_d = 1'b0;
        end
        if (push_req && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    // Transmit FSM next-state; each bit is held until the down-counter hits zero
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        pop       = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = TX_START;
                    shreg_d = fifo_rdata;
                    par_d   = ^fifo_rdata;
                    cnt_d   = div_q;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    state_d   = TX_DATA;
                    bit_idx_d = 3'd0;
                    cnt_d     = div_q;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    cnt_d     = div_q;
                    shreg_d   = {1'b0, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef MIPS_UART_TX_PARITY_EN
                        state_d = TX_PARITY;
`else
                        state_d = TX_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            TX_PARITY: begin
                if (bit_end) begin
                    state_d = TX_STOP;
                    cnt_d   = div_q;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = TX_START;
                        shreg_d = fifo_rdata;
                        par_d   = ^fifo_rdata;
                        cnt_d   = div_q;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase

        case (state_d)
            TX_START:  txd_d = 1'b0;
            TX_DATA:   txd_d = shreg_d[0];
            TX_PARITY: txd_d = par_d;
            default:   txd_d = 1'b1;
        endcase
    end

    // FSM, shifter and line registers; reset forces the line idle-high at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= TX_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            txd_q     <= txd_d;
        end
    end

    // Bus-visible configuration and sticky flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= DEFAULT_DIV;
            ovf_q <= 1'b0;
        end else begin
            div_q <= div_d;
            ovf_q <= ovf_d;
        end
    end

    // Interrupt follows idle-and-empty one clock later
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q <= 1'b1;
        end else begin
            irq_q <= (state_q == TX_IDLE) && fifo_empty;
        end
    end

    assign txd = txd_q;
    assign irq = irq_q;

endmodule

// File: tb/tb_mips_uart_tx_mmio.sv
// tb/tb_mips_uart_tx_mmio.sv - self-checking bench for mips_uart_tx_mmio
module tb_mips_uart_tx_mmio;

`ifdef MIPS_UART_TX_PARITY_EN
    localparam int          NBITS = 11;
    localparam logic [31:0] PARB  = 32'h200;
`else
    localparam int          NBITS = 10;
    localparam logic [31:0] PARB  = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        cs;
    logic [31:0] addr;
    logic        we;
    logic [1:0]  byte_width;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic        txd;
    logic        irq;

    int   n_checks = 0;
    int   n_errors = 0;
    logic last_err;

    mips_uart_tx_mmio #(
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (16'd433)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cs         (cs),
        .addr       (addr),
        .we         (we),
        .byte_width (byte_width),
        .wdata      (wdata),
        .rdata      (rdata),
        .err        (err),
        .txd        (txd),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] st(input bit b, input bit f, input bit e, input bit o, input int c);
        return PARB | (32'(c) << 4) | (o ? 32'h8 : 0) | (e ? 32'h4 : 0) | (f ? 32'h2 : 0) | (b ? 32'h1 : 0);
    endfunction

    // All bus tasks start and end just after a falling edge
    task automatic bus_wr(input logic [31:0] a, input logic [1:0] bw, input logic [31:0] d);
        cs = 1'b1; we = 1'b1; addr = a; byte_width = bw; wdata = d;
        #1 last_err = err;
        @(negedge clk);
        cs = 1'b0; we = 1'b0; addr = '0; byte_width = 2'b00; wdata = '0;
    endtask

    task automatic bus_rd(input logic [31:0] a, input logic [1:0] bw, output logic [31:0] rd, output logic er);
        cs = 1'b1; we = 1'b0; addr = a; byte_width = bw;
        #1;
        rd = rdata;
        er = err;
        cs = 1'b0; addr = '0; byte_width = 2'b00;
    endtask

    task automatic check_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] v;
        logic e;
        bus_rd(a, 2'b10, v, e);
        check(tag, v, exp);
    endtask

    // Line receiver: samples every clock, requires each bit to stay stable for div+1 clocks
    task automatic rx_frame(input int div, output logic [7:0] b, output logic p,
                            output logic bad, output int waited);
        bad = 1'b0; b = '0; p = 1'b0; waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (txd !== 1'b0 && waited < 5000);
        if (txd !== 1'b0) begin
            bad = 1'b1;
            return;
        end
        repeat (div) begin
            @(negedge clk);
            if (txd !== 1'b0) bad = 1'b1;
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            b[i] = txd;
            repeat (div) begin
                @(negedge clk);
                if (txd !== b[i]) bad = 1'b1;
            end
        end
        if (NBITS == 11) begin
            @(negedge clk);
            p = txd;
            repeat (div) begin
                @(negedge clk);
                if (txd !== p) bad = 1'b1;
            end
        end
        repeat (div + 1) begin
            @(negedge clk);
            if (txd !== 1'b1) bad = 1'b1;
        end
    endtask

    logic [7:0]  ovf_bytes [10];
    logic [7:0]  exp_q [$];

    initial begin
        logic [31:0] v;
        logic        e;
        logic [7:0]  b;
        logic        p;
        logic        bad;
        int          w;
        int          len;
        logic [NBITS-1:0] got_bits, exp_bits;

        reset = 1'b1; cs = 1'b0; we = 1'b0; addr = '0; byte_width = 2'b00; wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_txd", 32'(txd), 1);
        check("rst_irq", 32'(irq), 1);
        check("rst_rdata_nocs", rdata, 0);
        check("rst_err_nocs", 32'(err), 0);
        check_reg("rst_status", 32'h4, st(0, 0, 1, 0, 0));
        check_reg("rst_bauddiv", 32'h8, 433);

        // Single frame of 0x55 at DIV=3
        bus_wr(32'h8, 2'b10, 32'd3);
        bus_wr(32'h0, 2'b10, 32'h55);
        check("push_status", dut.rdata === 32'hx ? 0 : 1, 1);
        check_reg("push_status_cnt", 32'h4, st(0, 0, 0, 0, 1));
        check("pre_start_txd", 32'(txd), 1);
        rx_frame(3, b, p, bad, w);
        check("f55_latency", w, 1);
        check("f55_byte", 32'(b), 32'h55);
        check("f55_framing", 32'(bad), 0);
        check_reg("f55_busy_stop", 32'h4, st(1, 0, 1, 0, 0));
        check("f55_irq_stop", 32'(irq), 0);
        @(negedge clk);
        check_reg("f55_busy_clear", 32'h4, st(0, 0, 1, 0, 0));
        check("f55_irq_lag", 32'(irq), 0);
        @(negedge clk);
        check("f55_irq_set", 32'(irq), 1);

        // FIFO fill and overflow at DIV=100
        for (int i = 0; i < 10; i++) ovf_bytes[i] = 8'($urandom);
        bus_wr(32'h8, 2'b10, 32'd100);
        fork
            begin
                for (int i = 0; i < 9; i++) bus_wr(32'h0, 2'b00, {24'd0, ovf_bytes[i]});
                check_reg("fill_status", 32'h4, st(1, 1, 0, 0, 8));
                bus_wr(32'h0, 2'b00, {24'd0, ovf_bytes[9]});
                check_reg("ovf_status", 32'h4, st(1, 1, 0, 1, 8));
                bus_wr(32'h4, 2'b10, 32'h8);
                check_reg("w1c_status", 32'h4, st(1, 1, 0, 0, 8));
            end
            begin
                for (int i = 0; i < 9; i++) begin
                    rx_frame(100, b, p, bad, w);
                    check($sformatf("ovf_rx%0d", i), 32'(b), 32'(ovf_bytes[i]));
                    check($sformatf("ovf_fr%0d", i), 32'(bad), 0);
                end
            end
        join
        repeat (2) @(negedge clk);
        check_reg("drain_status", 32'h4, st(0, 0, 1, 0, 0));

        // Access errors
        bus_rd(32'h4, 2'b00, v, e);  check("err_byte_status", 32'(e), 1);
        bus_rd(32'h8, 2'b01, v, e);  check("err_half_baud", 32'(e), 1);
        bus_rd(32'h0, 2'b11, v, e);  check("err_bw11", 32'(e), 1);
        bus_rd(32'h1, 2'b01, v, e);  check("err_half_misal", 32'(e), 1);
        bus_rd(32'h2, 2'b10, v, e);  check("err_word_misal", 32'(e), 1);
        bus_rd(32'h3, 2'b00, v, e);  check("ok_byte_txdata", 32'(e), 0);
        check("ok_txdata_rd", v, 0);
        bus_rd(32'h8, 2'b10, v, e);  check("ok_baud_err", 32'(e), 0);
        check("ok_baud_rd", v, 100);
        bus_wr(32'hC, 2'b10, 32'hFF);
        check("err_wr_rsvd", 32'(last_err), 1);
        bus_wr(32'h8, 2'b00, 32'd5);
        check("err_wr_baud_byte", 32'(last_err), 1);
        bus_wr(32'h0, 2'b11, 32'h12);
        check("err_wr_bw11", 32'(last_err), 1);
        check_reg("err_no_push", 32'h4, st(0, 0, 1, 0, 0));
        check_reg("err_baud_kept", 32'h8, 100);

        // Mid-bit divisor change, then reset during DATA bit 3
        bus_wr(32'h8, 2'b10, 32'd7);
        bus_wr(32'h0, 2'b00, 32'h55);
        check("mb_pre_txd", 32'(txd), 1);
        bus_wr(32'h0, 2'b00, 32'hAA);
        check("mb_s1", 32'(txd), 0);
        bus_wr(32'h0, 2'b00, 32'h33);
        bus_wr(32'h8, 2'b10, 32'd1);
        len = 3;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (txd !== 1'b0) break;
            len++;
        end
        check("mb_start_len", len, 8);
        len = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (txd !== 1'b1) break;
            len++;
        end
        check("mb_bit0_len", len, 2);
        len = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (txd !== 1'b0) break;
            len++;
        end
        check("mb_bit1_len", len, 2);
        @(negedge clk);
        @(negedge clk);
        check("mb_bit3_low", 32'(txd), 0);
        reset = 1'b1;
        #1;
        check("arst_txd", 32'(txd), 1);
        check("arst_irq", 32'(irq), 1);
        check_reg("arst_status", 32'h4, st(0, 0, 1, 0, 0));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_irq", 32'(irq), 1);
        check("post_rst_txd", 32'(txd), 1);
        check_reg("post_rst_status", 32'h4, st(0, 0, 1, 0, 0));
        check_reg("post_rst_baud", 32'h8, 433);

        // DIV=0 frame of 0x07: one clock per bit
        bus_wr(32'h8, 2'b10, 32'd0);
        bus_wr(32'h0, 2'b00, 32'h07);
        exp_bits = '1;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[i+1] = (8'h07 >> i) & 1;
        if (NBITS == 11) exp_bits[9] = 1'b1;
        got_bits = '0;
        len = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            bus_rd(32'h4, 2'b10, v, e);
            if (v[0] !== 1'b1) break;
            if (len < NBITS) got_bits[len] = txd;
            len++;
        end
        check("d0_frame_len", len, NBITS);
        check("d0_frame_bits", 32'(got_bits), 32'(exp_bits));

        // Randomized rounds against a byte-queue model
        for (int r = 0; r < 8; r++) begin
            int div;
            int n;
            div = $urandom_range(0, 5);
            n   = $urandom_range(1, 7);
            bus_wr(32'h8, 2'b10, 32'(div));
            fork
                begin
                    for (int i = 0; i < n; i++) begin
                        logic [7:0]  d;
                        logic [1:0]  bw;
                        logic [31:0] a;
                        d  = 8'($urandom);
                        bw = 2'($urandom_range(0, 2));
                        if (bw == 2'b00)      a = 32'($urandom_range(0, 3));
                        else if (bw == 2'b01) a = 32'($urandom_range(0, 1)) << 1;
                        else                  a = 32'h0;
                        a = a | ($urandom & 32'hFFFF_FFF0);
                        exp_q.push_back(d);
                        bus_wr(a, bw, {$urandom} & 32'hFFFF_FF00 | 32'(d));
                        repeat ($urandom_range(0, 3)) @(negedge clk);
                    end
                end
                begin
                    for (int i = 0; i < n; i++) begin
                        logic [7:0] expb;
                        rx_frame(div, b, p, bad, w);
                        expb = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
                        check($sformatf("rnd%0d_byte%0d", r, i), 32'(b), 32'(expb));
                        check($sformatf("rnd%0d_frame%0d", r, i), 32'(bad), 0);
`ifdef MIPS_UART_TX_PARITY_EN
                        check($sformatf("rnd%0d_par%0d", r, i), 32'(p), 32'($countones(expb) % 2));
`endif
                    end
                end
            join
            repeat (3) @(negedge clk);
            check($sformatf("rnd%0d_idle_irq", r), 32'(irq), 1);
            check_reg($sformatf("rnd%0d_idle_status", r), 32'h4, st(0, 0, 1, 0, 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
